controle: RTL and testbench

Instruction sequencer for the 8-bit stack CPU, sitting directly upstream of the stack/register/ALU/filter datapath. It fetches 13-bit instructions from a synchronous program ROM, decodes them, and drives the datapath strobes: `pop`, `push`, operand loads, `opcode` and `imm`. It tracks stack empty/full to trap underflow and overflow, and resolves jumps using the current top of stack.

---
 rtl/controle_pkg.sv | 57 +++++
 rtl/controle_dec.sv | 31 +++
 rtl/controle.sv | 174 +++++++++++++++++
 tb/tb_controle.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controle_pkg
// Description : Shared opcodes, sequencer states and instruction classes for
//               the 8-bit stack CPU instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package controle_pkg;

  // Opcode values carried in instr[12:8]
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_PUSHI = 5'b00001;
  localparam logic [4:0] OP_PUSHD = 5'b00010;
  localparam logic [4:0] OP_DROP  = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_OR    = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01000;
  localparam logic [4:0] OP_NOT   = 5'b01001;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JZ    = 5'b10001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPB    = 3'd3,
    ST_OPA    = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_PUSH   = 3'd1,
    CL_DROP   = 3'd2,
    CL_UNARY  = 3'd3,
    CL_BINARY = 3'd4,
    CL_JMP    = 3'd5,
    CL_JZ     = 3'd6,
    CL_HALT   = 3'd7
  } iclass_e;

  // Number of stack entries an instruction class consumes before it runs
  function automatic logic [1:0] operands_needed(input iclass_e c);
    case (c)
      CL_BINARY:                  return 2'd2;
      CL_UNARY, CL_DROP, CL_JZ:   return 2'd1;
      default:                    return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_dec.sv
`default_nettype none
// ============================================================================
// Module      : controle_dec
// Description : Combinational opcode to instruction-class decoder. Unknown
//               opcodes fall into CL_NONE and therefore behave as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_dec
  import controle_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    class_o
);

  // Map each opcode onto the class that selects its sequencing path
  always_comb begin
    class_o = CL_NONE;
    case (opcode_i)
      OP_PUSHI, OP_PUSHD:                  class_o = CL_PUSH;
      OP_DROP:                             class_o = CL_DROP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: class_o = CL_BINARY;
      OP_NOT:                              class_o = CL_UNARY;
      OP_JMP:                              class_o = CL_JMP;
      OP_JZ:                               class_o = CL_JZ;
      OP_HALT:                             class_o = CL_HALT;
      default:                             class_o = CL_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/controle.sv
`default_nettype none
// ============================================================================
// Module      : controle
// Description : Instruction sequencer for the 8-bit stack CPU. Fetches from a
//               synchronous ROM, decodes, pops operands with underflow trap,
//               pushes results with overflow trap and resolves JMP/JZ.
// Revision    : 1.0 - initial release
// ============================================================================
module controle
  import controle_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            run,
  input  logic [12:0]     instr,
  input  logic            empty,
  input  logic            full,
  input  logic [7:0]      top,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      opcode,
  output logic [7:0]      imm,
  output logic            pop,
  output logic            push,
  output logic            load1,
  output logic            load2,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [4:0]      opcode_q;
  logic [7:0]      imm_q;
  iclass_e         cls_q;
  logic [1:0]      cnt_q;
  logic            busy_q;
  logic            halted_q;
  logic            err_q;

  iclass_e         dec_cls;

  // The decoder only ever looks at the word arriving from the ROM; later
  // states use the class latched at DECODE.
  controle_dec u_dec (
    .opcode_i (instr[12:8]),
    .class_o  (dec_cls)
  );

  // Stack strobes are gated in the same cycle by the flag being sampled, so
  // a faulting pop/push never reaches the datapath.
  always_comb begin
    pop   = 1'b0;
    push  = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    case (state_q)
      ST_OPB: begin
        pop   = !empty;
        load2 = !empty && ((cls_q == CL_BINARY) || (cls_q == CL_UNARY));
      end
      ST_OPA: begin
        pop   = !empty;
        load1 = !empty;
      end
      ST_EXEC: push = !full;
      default: ;
    endcase
  end

  // Sequencer FSM together with pc, latched instruction fields and status flags
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      opcode_q <= OP_NOP;
      imm_q    <= 8'h00;
      cls_q    <= CL_NONE;
      cnt_q    <= 2'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end

        ST_FETCH: state_q <= ST_DECODE;

        ST_DECODE: begin
          opcode_q <= instr[12:8];
          imm_q    <= instr[7:0];
          cls_q    <= dec_cls;
          cnt_q    <= operands_needed(dec_cls);
          pc_q     <= pc_q + PC_W'(1);
          case (dec_cls)
            CL_HALT: begin
              state_q  <= ST_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
            CL_JMP: begin
              pc_q    <= PC_W'(instr[7:0]);
              state_q <= ST_FETCH;
            end
            CL_BINARY, CL_UNARY, CL_DROP, CL_JZ: state_q <= ST_OPB;
            CL_PUSH:                             state_q <= ST_EXEC;
            default:                             state_q <= ST_FETCH;
          endcase
        end

        ST_OPB: begin
          if (empty) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
            if ((cls_q == CL_JZ) || (cls_q == CL_DROP)) begin
              if ((cls_q == CL_JZ) && (top == 8'h00)) begin
                pc_q <= PC_W'(imm_q);
              end
              state_q <= ST_FETCH;
            end else if (cnt_q == 2'd2) begin
              state_q <= ST_OPA;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end

        ST_OPA: begin
          if (empty) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 2'd1;
            state_q <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (full) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end

        ST_HALT: state_q <= ST_HALT;
        ST_ERR:  state_q <= ST_ERR;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc     = pc_q;
  assign opcode = opcode_q;
  assign imm    = imm_q;
  assign busy   = busy_q;
  assign halted = halted_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_controle.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle
// Description : Bench for controle. A small stack datapath reacts to the DUT
//               strobes; an instruction-level reference produces the expected
//               per-cycle output trace for each program.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle;

  localparam int CAP = 8;

  localparam logic [4:0] B_PUSHI = 5'd1;
  localparam logic [4:0] B_PUSHD = 5'd2;
  localparam logic [4:0] B_DROP  = 5'd3;
  localparam logic [4:0] B_ADD   = 5'd4;
  localparam logic [4:0] B_SUB   = 5'd5;
  localparam logic [4:0] B_AND   = 5'd6;
  localparam logic [4:0] B_OR    = 5'd7;
  localparam logic [4:0] B_XOR   = 5'd8;
  localparam logic [4:0] B_NOT   = 5'd9;
  localparam logic [4:0] B_JMP   = 5'd16;
  localparam logic [4:0] B_JZ    = 5'd17;
  localparam logic [4:0] B_HALT  = 5'd31;

  // {pop, push, load1, load2, busy, halted, err}
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_BUSY = 7'b0000100;
  localparam logic [6:0] F_POPB = 7'b1001100;
  localparam logic [6:0] F_POP  = 7'b1000100;
  localparam logic [6:0] F_POPA = 7'b1010100;
  localparam logic [6:0] F_PUSH = 7'b0100100;
  localparam logic [6:0] F_HALT = 7'b0000010;
  localparam logic [6:0] F_ERR  = 7'b0000001;

  typedef struct packed {
    logic [7:0] pc;
    logic [4:0] op;
    logic [7:0] imm;
    logic       pop;
    logic       push;
    logic       l1;
    logic       l2;
    logic       busy;
    logic       halted;
    logic       err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rstn, run;
  logic [12:0] instr;
  logic        empty, full;
  logic [7:0]  top;
  logic [7:0]  pc;
  logic [4:0]  opcode;
  logic [7:0]  imm;
  logic        pop, push, load1, load2, busy, halted, err;

  always #5 clk = ~clk;

  controle #(.PC_W(8)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .run    (run),
    .instr  (instr),
    .empty  (empty),
    .full   (full),
    .top    (top),
    .pc     (pc),
    .opcode (opcode),
    .imm    (imm),
    .pop    (pop),
    .push   (push),
    .load1  (load1),
    .load2  (load2),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  logic [12:0] rom [0:255];
  logic [7:0]  env_stk [0:CAP-1];
  int          env_depth = 0;
  logic [7:0]  t1, t2, ext_data;
  logic [7:0]  init_vals[$];
  rec_t        exp_q[$];
  rec_t        hist[$];
  int          errors = 0;
  int          checks = 0;

  // Stack flags and top-of-stack as the datapath would present them
  always_comb begin
    empty = (env_depth == 0);
    full  = (env_depth >= CAP);
    top   = (env_depth > 0) ? env_stk[3'(env_depth - 1)] : 8'h00;
  end

  function automatic rec_t mk(input logic [7:0] p, input logic [4:0] o,
                              input logic [7:0] i, input logic [6:0] f);
    return {p, o, i, f};
  endfunction

  // Value pushed for an instruction; a is the deeper operand, b the top one
  function automatic logic [7:0] result(input logic [4:0] o, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] i);
    case (o)
      B_PUSHI: return i;
      B_PUSHD: return ext_data;
      B_ADD:   return a + b;
      B_SUB:   return a - b;
      B_AND:   return a & b;
      B_OR:    return a | b;
      B_XOR:   return a ^ b;
      B_NOT:   return ~b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Instruction-level reference: walks the program and lists every cycle's outputs
  task automatic build_model(input int max_instr);
    logic [7:0]  stk[$];
    logic [7:0]  a, b, pcv, im;
    logic [4:0]  op;
    logic [12:0] w;
    int          need;
    bit          pushes, alu_in, failed;
    stk = init_vals;
    pcv = 8'h00; op = 5'd0; im = 8'h00; a = 8'h00; b = 8'h00; failed = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(pcv, op, im, F_IDLE));
    for (int n = 0; n < max_instr; n++) begin
      w = rom[pcv];
      exp_q.push_back(mk(pcv, op, im, F_BUSY));   // fetch
      exp_q.push_back(mk(pcv, op, im, F_BUSY));   // decode
      op  = w[12:8];
      im  = w[7:0];
      pcv = pcv + 8'd1;
      if (op == B_HALT) begin
        repeat (3) exp_q.push_back(mk(pcv, op, im, F_HALT));
        return;
      end
      if (op == B_JMP) begin
        pcv = im;
        continue;
      end
      need   = (op >= B_ADD && op <= B_XOR) ? 2 :
               (op == B_NOT || op == B_DROP || op == B_JZ) ? 1 : 0;
      pushes = (op == B_PUSHI || op == B_PUSHD || (op >= B_ADD && op <= B_NOT));
      alu_in = (op >= B_ADD && op <= B_NOT);
      if (need >= 1) begin
        if (stk.size() == 0) begin
          exp_q.push_back(mk(pcv, op, im, F_BUSY));
          failed = 1'b1;
        end else begin
          exp_q.push_back(mk(pcv, op, im, alu_in ? F_POPB : F_POP));
          b = stk.pop_back();
          if (op == B_JZ && b == 8'h00) pcv = im;
        end
      end
      if (!failed && need == 2) begin
        if (stk.size() == 0) begin
          exp_q.push_back(mk(pcv, op, im, F_BUSY));
          failed = 1'b1;
        end else begin
          exp_q.push_back(mk(pcv, op, im, F_POPA));
          a = stk.pop_back();
        end
      end
      if (!failed && pushes) begin
        if (stk.size() >= CAP) begin
          exp_q.push_back(mk(pcv, op, im, F_BUSY));
          failed = 1'b1;
        end else begin
          exp_q.push_back(mk(pcv, op, im, F_PUSH));
          stk.push_back(result(op, a, b, im));
        end
      end
      if (failed) begin
        repeat (3) exp_q.push_back(mk(pcv, op, im, F_ERR));
        return;
      end
    end
  endtask

  // One clock: compare at negedge, then let the ROM and stack react after the edge
  task automatic cycle(input bit do_chk, input int k);
    rec_t       cur;
    logic [7:0] tp;
    @(negedge clk);
    cur = {pc, opcode, imm, pop, push, load1, load2, busy, halted, err};
    hist.push_back(cur);
    if (do_chk && k < exp_q.size())
      chk($sformatf("cyc%0d", k), {4'b0, cur}, {4'b0, exp_q[k]});
    @(posedge clk);
    #1;
    tp = top;
    if (cur.l1) t1 = tp;
    if (cur.l2) t2 = tp;
    if (cur.pop && env_depth > 0) env_depth--;
    if (cur.push && env_depth < CAP) begin
      env_stk[3'(env_depth)] = result(cur.op, t1, t2, cur.imm);
      env_depth++;
    end
    instr = rom[cur.pc];
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 13'h0000;
  endtask

  task automatic start_test();
    env_depth = init_vals.size();
    for (int i = 0; i < init_vals.size(); i++) env_stk[i] = init_vals[i];
    t1 = 8'h00; t2 = 8'h00; instr = 13'h0000;
    rstn = 1'b1; run = 1'b0;
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    rstn = 1'b0; run = 1'b1;
    hist.delete();
  endtask

  task automatic run_model(input int max_instr);
    build_model(max_instr);
    for (int k = 0; k < exp_q.size(); k++) begin
      cycle(1'b1, k);
      if (k == 0) run = 1'b0;
    end
  endtask

  initial begin
    int first_h;
    logic [4:0] optab [0:15];
    rstn = 1'b1; run = 1'b0; instr = 13'h0000; ext_data = 8'h5A;
    t1 = 8'h00; t2 = 8'h00;

    // PUSHI 5, PUSHI 3, ADD, HALT
    clear_rom();
    rom[0] = {B_PUSHI, 8'd5}; rom[1] = {B_PUSHI, 8'd3};
    rom[2] = {B_ADD, 8'd0};   rom[3] = {B_HALT, 8'd0};
    init_vals = {};
    start_test();
    run_model(10);
    first_h = -1;
    for (int k = hist.size() - 1; k >= 0; k--) if (hist[k].halted) first_h = k;
    chk("t1_halt_cycle", first_h, 14);
    chk("t1_push5", {hist[3].push, hist[3].imm}, {1'b1, 8'd5});
    chk("t1_push3", {hist[6].push, hist[6].imm}, {1'b1, 8'd3});
    chk("t1_opb", {hist[9].pop, hist[9].l2, hist[9].l1}, 3'b110);
    chk("t1_opa", {hist[10].pop, hist[10].l1, hist[10].l2}, 3'b110);
    chk("t1_addpush", {hist[11].push, hist[11].op}, {1'b1, 5'b00100});
    chk("t1_sum", {env_depth[7:0], env_stk[0]}, {8'd1, 8'd8});

    // JZ taken
    clear_rom();
    rom[0] = {B_PUSHI, 8'd0}; rom[1] = {B_JZ, 8'h05};
    rom[2] = {B_HALT, 8'd0};  rom[5] = {B_HALT, 8'd0};
    init_vals = {};
    start_test();
    run_model(6);
    chk("t2_jz_pop", hist[6].pop, 1'b1);
    chk("t2_jz_taken_pc", hist[7].pc, 8'h05);

    // JZ not taken
    rom[0] = {B_PUSHI, 8'd7};
    start_test();
    run_model(6);
    chk("t2_jz_fall_pc", hist[7].pc, 8'h02);

    // ADD with one entry: underflow in OPA
    clear_rom();
    rom[0] = {B_ADD, 8'd0};
    init_vals = {8'd4};
    start_test();
    run_model(5);
    chk("t3_opa_quiet", {hist[4].pop, hist[4].l1}, 2'b00);
    chk("t3_err", {hist[5].err, hist[6].err, hist[6].busy}, 3'b110);

    // PUSHI into a full stack: overflow in EXEC
    clear_rom();
    rom[0] = {B_PUSHI, 8'd1};
    init_vals = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    start_test();
    run_model(5);
    chk("t4_no_push", hist[3].push, 1'b0);
    chk("t4_err", hist[4].err, 1'b1);

    // JMP 0xFF, NOP at 0xFF, pc wraps to 0
    clear_rom();
    rom[0] = {B_JMP, 8'hFF}; rom[255] = {5'd0, 8'd0};
    init_vals = {};
    start_test();
    run_model(6);
    chk("t5_pc_ff", hist[3].pc, 8'hFF);
    chk("t5_pc_wrap", hist[5].pc, 8'h00);

    // Reset asserted during OPA of a binary op
    clear_rom();
    rom[0] = {B_ADD, 8'd0}; rom[1] = {B_HALT, 8'd0};
    init_vals = {8'd2, 8'd3};
    start_test();
    build_model(2);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, k);
      if (k == 0) run = 1'b0;
      if (k == 3) rstn = 1'b1;
    end
    cycle(1'b0, 5);
    chk("t6_reset_vals", {4'b0, hist[5]}, 32'h0);
    rstn = 1'b0;
    cycle(1'b0, 6);
    chk("t6_stay_idle", {4'b0, hist[6]}, 32'h0);

    // Randomised programs
    optab = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
              5'd7, 5'd8, 5'd9, 5'd16, 5'd17, 5'd17, 5'd31, 5'd12};
    for (int t = 0; t < 8; t++) begin
      logic [4:0] o;
      logic [7:0] iv;
      for (int i = 0; i < 256; i++) begin
        o = optab[$urandom_range(0, 15)];
        if (o == B_JMP || o == B_JZ) iv = 8'($urandom_range(0, 40));
        else if ($urandom_range(0, 1) == 1) iv = 8'($urandom_range(0, 3));
        else iv = 8'($urandom);
        rom[i] = {o, iv};
      end
      init_vals = {};
      for (int i = 0; i < int'($urandom_range(0, CAP)); i++)
        init_vals.push_back(8'($urandom_range(0, 2)));
      ext_data = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      start_test();
      run_model(60);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
